instr_fetch_ctrl: RTL and testbench

- Sequences the single-cycle, combinational-read, word-indexed instruction memory (32 x 32-bit words).
- Owns the fetch PC, drives the memory address, and registers each returned word.
- Presents the registered word to decode through a valid/ready handshake.
- Handles stall (back-pressure), branch redirect with flush, a halt-word stop condition, and a saturating count of delivered instructions.

---
 rtl/instr_fetch_ctrl.sv | 95 +++++++++
 tb/tb_instr_fetch_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, registers each memory word
// and hands it to decode over valid/ready, with stall, branch flush and halt.
module instr_fetch_ctrl #(
   parameter int          IMEM_DEPTH = 32,
   parameter int          RESET_PC   = 0,
   parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic [31:0] inst_out,
   output logic [31:0] pc_out,
   output logic        inst_valid,
   input  logic        inst_ready,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        halted,
   output logic [15:0] fetch_count
);

   localparam int IDX_W = $clog2(IMEM_DEPTH);
   localparam logic [IDX_W-1:0] RST_IDX = IDX_W'(RESET_PC);

   typedef enum logic {S_FETCH, S_HALT} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] fpc_q, fpc_d;
   logic [IDX_W-1:0] pc_q, pc_d;
   logic [31:0]      inst_q, inst_d;
   logic             valid_q, valid_d;
   logic [15:0]      cnt_q, cnt_d;
   logic             slot_free, accept;

   assign slot_free = !valid_q || inst_ready;
   assign accept    = valid_q && inst_ready && !branch_taken;

   always_comb begin
      state_d = state_q;
      fpc_d   = fpc_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      if (accept && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      if (branch_taken) begin
         // Redirect flushes the held word even if decode takes it this cycle.
         fpc_d   = branch_target[IDX_W-1:0];
         valid_d = 1'b0;
         state_d = S_FETCH;
      end else begin
         case (state_q)
            S_FETCH: begin
               if (slot_free) begin
                  inst_d  = imem_data;
                  pc_d    = fpc_q;
                  valid_d = 1'b1;
                  if (imem_data == HALT_WORD) state_d = S_HALT;
                  else                        fpc_d   = fpc_q + IDX_W'(1);
               end
            end
            S_HALT: begin
               if (valid_q && inst_ready) valid_d = 1'b0;
            end
            default: state_d = S_FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         fpc_q   <= RST_IDX;
         pc_q    <= '0;
         inst_q  <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         fpc_q   <= fpc_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign imem_addr   = {{(32-IDX_W){1'b0}}, fpc_q};
   assign pc_out      = {{(32-IDX_W){1'b0}}, pc_q};
   assign inst_out    = inst_q;
   assign inst_valid  = valid_q;
   assign halted      = (state_q == S_HALT);
   assign fetch_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed scenarios plus a randomized run scored
// against a transaction-level model of the fetch stream.
module tb_instr_fetch_ctrl;

   localparam logic [31:0] HALT = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst, inst_ready, branch_taken;
   logic [31:0] branch_target;
   logic [31:0] imem_addr, imem_data, inst_out, pc_out;
   logic        inst_valid, halted;
   logic [15:0] fetch_count;

   logic [31:0] mem [32];
   assign imem_data = mem[imem_addr[4:0]];

   always #5 clk = ~clk;

   instr_fetch_ctrl dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
      .inst_out(inst_out), .pc_out(pc_out), .inst_valid(inst_valid),
      .inst_ready(inst_ready), .branch_taken(branch_taken),
      .branch_target(branch_target), .halted(halted), .fetch_count(fetch_count)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: next index to fetch, word held for decode, stopped flag.
   int          m_next;
   bit          m_valid, m_stop;
   logic [31:0] m_inst;
   int          m_pc;
   int          m_cnt;

   task automatic step(input bit r, input bit rdy, input bit br, input logic [31:0] tgt);
      logic [31:0] w;
      rst = r; inst_ready = rdy; branch_taken = br; branch_target = tgt;
      if (r) begin
         m_next = 0; m_valid = 0; m_stop = 0; m_inst = 0; m_pc = 0; m_cnt = 0;
      end else if (br) begin
         m_next = int'(tgt % 32); m_valid = 0; m_stop = 0;
      end else begin
         if (m_valid && rdy && m_cnt < 65535) m_cnt++;
         if (!m_stop) begin
            if (!m_valid || rdy) begin
               w = mem[m_next];
               m_inst = w; m_pc = m_next; m_valid = 1;
               if (w == HALT) m_stop = 1;
               else m_next = (m_next + 1) % 32;
            end
         end else if (m_valid && rdy) begin
            m_valid = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic load_ramp();
      for (int i = 0; i < 32; i++) mem[i] = 32'(i + 100);
   endtask

   task automatic test_reset();
      step(1, 1, 0, 0);
      step(1, 1, 0, 0);
      n_tests++;
      if ({inst_valid, halted, inst_out, pc_out, fetch_count, imem_addr} !==
          {1'b0, 1'b0, 32'd0, 32'd0, 16'd0, 32'd0}) begin
         n_fail++;
         $display("FAIL reset: valid=%0b halted=%0b inst=%h pc=%0d cnt=%0d addr=%0d, want all 0",
                  inst_valid, halted, inst_out, pc_out, fetch_count, imem_addr);
      end
   endtask

   task automatic test_stream();
      step(0, 1, 0, 0);
      n_tests++;
      if (!(inst_valid === 1'b1 && inst_out === 32'd100 && pc_out === 32'd0 && fetch_count === 16'd0)) begin
         n_fail++;
         $display("FAIL first_fetch: valid=%0b inst=%0d pc=%0d cnt=%0d, want 1/100/0/0",
                  inst_valid, inst_out, pc_out, fetch_count);
      end
      for (int k = 1; k <= 3; k++) begin
         step(0, 1, 0, 0);
         n_tests++;
         if (!(inst_out === 32'(100 + k) && pc_out === 32'(k) && fetch_count === 16'(k))) begin
            n_fail++;
            $display("FAIL stream_%0d: inst=%0d pc=%0d cnt=%0d, want %0d/%0d/%0d",
                     k, inst_out, pc_out, fetch_count, 100 + k, k, k);
         end
      end
   endtask

   task automatic run_to_pc(input int target, input string name);
      int budget = 100;
      while (!(inst_valid === 1'b1 && pc_out === 32'(target)) && budget > 0) begin
         step(0, 1, 0, 0);
         budget--;
      end
      if (budget == 0) begin
         n_tests++; n_fail++;
         $display("FAIL %s_timeout: pc=%0d, want %0d", name, pc_out, target);
      end
   endtask

   task automatic test_stall();
      logic [15:0] c0;
      run_to_pc(5, "stall");
      c0 = fetch_count;
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 0, 0);
         n_tests++;
         if (!(inst_out === 32'd105 && pc_out === 32'd5 && imem_addr === 32'd6 &&
               inst_valid === 1'b1 && fetch_count === c0)) begin
            n_fail++;
            $display("FAIL stall_%0d: inst=%0d pc=%0d addr=%0d cnt=%0d, want 105/5/6/%0d",
                     k, inst_out, pc_out, imem_addr, fetch_count, c0);
         end
      end
      step(0, 1, 0, 0);
      n_tests++;
      if (!(inst_out === 32'd106 && pc_out === 32'd6 && fetch_count === c0 + 16'd1)) begin
         n_fail++;
         $display("FAIL stall_release: inst=%0d pc=%0d cnt=%0d, want 106/6/%0d",
                  inst_out, pc_out, fetch_count, c0 + 16'd1);
      end
   endtask

   task automatic test_branch();
      logic [15:0] c0;
      step(1, 1, 0, 0);
      run_to_pc(3, "branch");
      c0 = fetch_count;
      step(0, 1, 1, 32'd20);
      n_tests++;
      if (!(inst_valid === 1'b0 && fetch_count === c0 && imem_addr === 32'd20)) begin
         n_fail++;
         $display("FAIL branch_bubble: valid=%0b cnt=%0d addr=%0d, want 0/%0d/20",
                  inst_valid, fetch_count, imem_addr, c0);
      end
      step(0, 1, 0, 0);
      n_tests++;
      if (!(inst_valid === 1'b1 && inst_out === 32'd120 && pc_out === 32'd20 && fetch_count === c0)) begin
         n_fail++;
         $display("FAIL branch_target: valid=%0b inst=%0d pc=%0d cnt=%0d, want 1/120/20/%0d",
                  inst_valid, inst_out, pc_out, fetch_count, c0);
      end
   endtask

   task automatic test_wrap();
      run_to_pc(31, "wrap");
      step(0, 1, 0, 0);
      n_tests++;
      if (!(pc_out === 32'd0 && inst_out === 32'd100)) begin
         n_fail++;
         $display("FAIL wrap: pc=%0d inst=%0d, want 0/100", pc_out, inst_out);
      end
      step(0, 1, 1, 32'h45);
      step(0, 1, 0, 0);
      n_tests++;
      if (!(pc_out === 32'd5 && inst_out === 32'd105 && inst_valid === 1'b1)) begin
         n_fail++;
         $display("FAIL wide_target: pc=%0d inst=%0d, want 5/105", pc_out, inst_out);
      end
   endtask

   task automatic test_halt();
      mem[4] = HALT;
      step(1, 1, 0, 0);
      run_to_pc(4, "halt");
      n_tests++;
      if (!(inst_out === HALT && inst_valid === 1'b1 && halted === 1'b1 && imem_addr === 32'd4)) begin
         n_fail++;
         $display("FAIL halt_present: inst=%h valid=%0b halted=%0b addr=%0d, want ffffffff/1/1/4",
                  inst_out, inst_valid, halted, imem_addr);
      end
      for (int k = 0; k < 3; k++) begin
         step(0, 1, 0, 0);
         n_tests++;
         if (!(inst_valid === 1'b0 && halted === 1'b1 && imem_addr === 32'd4 && fetch_count === 16'd5)) begin
            n_fail++;
            $display("FAIL halt_idle_%0d: valid=%0b halted=%0b addr=%0d cnt=%0d, want 0/1/4/5",
                     k, inst_valid, halted, imem_addr, fetch_count);
         end
      end
      step(0, 1, 1, 32'd0);
      step(0, 1, 0, 0);
      n_tests++;
      if (!(halted === 1'b0 && inst_valid === 1'b1 && pc_out === 32'd0 && inst_out === 32'd100)) begin
         n_fail++;
         $display("FAIL halt_resume: halted=%0b valid=%0b pc=%0d inst=%0d, want 0/1/0/100",
                  halted, inst_valid, pc_out, inst_out);
      end
   endtask

   task automatic test_reset_mid();
      // reset during a stall, then during HALT (mem[4] still holds the halt word)
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 1) run_to_pc(4, "rst_halt");
         step(1, 0, 0, 0);
         n_tests++;
         if ({inst_valid, halted, inst_out, pc_out, fetch_count, imem_addr} !==
             {1'b0, 1'b0, 32'd0, 32'd0, 16'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_mid_%0d: valid=%0b halted=%0b inst=%h pc=%0d cnt=%0d addr=%0d, want all 0",
                     pass, inst_valid, halted, inst_out, pc_out, fetch_count, imem_addr);
         end
         step(0, 1, 0, 0);
         n_tests++;
         if (!(inst_valid === 1'b1 && pc_out === 32'd0 && inst_out === 32'd100)) begin
            n_fail++;
            $display("FAIL reset_restart_%0d: valid=%0b pc=%0d inst=%0d, want 1/0/100",
                     pass, inst_valid, pc_out, inst_out);
         end
      end
      load_ramp();
   endtask

   task automatic test_random();
      bit r, rdy, br;
      logic [31:0] tgt;
      for (int i = 0; i < 32; i++)
         mem[i] = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
      step(1, 1, 0, 0);
      for (int c = 0; c < 600; c++) begin
         r   = ($urandom_range(0, 99) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         br  = ($urandom_range(0, 9) == 0);
         tgt = $urandom;
         step(r, rdy, br, tgt);
         n_tests++;
         if (inst_valid !== m_valid || halted !== m_stop || fetch_count !== 16'(m_cnt) ||
             imem_addr !== 32'(m_next) || (m_valid && (inst_out !== m_inst || pc_out !== 32'(m_pc)))) begin
            n_fail++;
            $display("FAIL random_c%0d: valid=%0b halted=%0b cnt=%0d addr=%0d inst=%h pc=%0d, want %0b/%0b/%0d/%0d/%h/%0d",
                     c, inst_valid, halted, fetch_count, imem_addr, inst_out, pc_out,
                     m_valid, m_stop, m_cnt, m_next, m_inst, m_pc);
         end
      end
   endtask

   initial begin
      rst = 1'b1; inst_ready = 1'b0; branch_taken = 1'b0; branch_target = '0;
      load_ramp();
      #1;
      test_reset();
      test_stream();
      test_stall();
      test_branch();
      test_wrap();
      test_halt();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
